mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory responder: a local word array behind a request/response handshake.
// Writes update the array in place and return nothing. Reads push the
// addressed word (or zero for a bad address) into a small in-order
// response FIFO. A credit count equal to the FIFO occupancy throttles
// REQ_READY. Any out-of-range or misaligned access sets a sticky ERR flag.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 8,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_ADDR_VALID,
  input  logic [31:0] REQ_ADDR,
  input  logic        REQ_DATA_VALID,
  input  logic [31:0] REQ_DATA,
  output logic        REQ_READY,
  output logic        RESP_VALID,
  output logic [31:0] RESP_DATA,
  input  logic        RESP_READY,
  output logic        ERR
);

  localparam int WORDS = 2 ** DEPTH_LOG2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // Storage: the array is never reset; the FIFO body needs no reset
  // because the pointers and credit define which entries are live.
  logic [31:0] mem_q  [WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             err_q, err_d;

  logic [31:0]           offset;
  logic [31:0]           offsetHigh;
  logic                  inRange;
  logic [DEPTH_LOG2-1:0] index;

  logic        pop;
  logic        accept;
  logic        acceptRead;
  logic        acceptWrite;
  logic [31:0] pushData;

  // Address decode: range and alignment check, then the truncated word index.
  always_comb begin
    offset     = REQ_ADDR - BASE_ADDR;
    offsetHigh = offset >> (DEPTH_LOG2 + 2);
    inRange    = (REQ_ADDR >= BASE_ADDR) && (offsetHigh == '0) &&
                 (REQ_ADDR[1:0] == 2'b00);
    index      = offset[DEPTH_LOG2+1:2];
  end

  // Handshakes: a full FIFO still accepts when its head leaves this cycle.
  always_comb begin
    RESP_VALID  = (credit_q != '0);
    pop         = RESP_VALID && RESP_READY;
    REQ_READY   = !RST && ((credit_q != FULL_COUNT) || pop);
    accept      = REQ_ADDR_VALID && REQ_READY;
    acceptWrite = accept && REQ_DATA_VALID;
    acceptRead  = accept && !REQ_DATA_VALID;
    pushData    = inRange ? mem_q[index] : 32'h0000_0000;
    RESP_DATA   = fifo_q[rdPtr_q];
    ERR         = err_q;
  end

  // Next-state for pointers, credit and the sticky error flag.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    credit_d = credit_q;
    err_d    = err_q;
    if (acceptRead) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({acceptRead, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
    if (accept && !inRange) begin
      err_d = 1'b1;
    end
  end

  // Control registers with synchronous reset; in-flight responses are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  // Array update: only accepted in-range writes land; reset leaves contents intact.
  always_ff @(posedge CLK) begin
    if (acceptWrite && inRange) begin
      mem_q[index] <= REQ_DATA;
    end
  end

  // Response FIFO body: a push into a full FIFO that is popping this cycle
  // reuses the head slot, which is read out before the edge.
  always_ff @(posedge CLK) begin
    if (acceptRead) begin
      fifo_q[wrPtr_q] <= pushData;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder with a queue/array model.
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DLOG2 = 4;
  localparam int          WORDS = 2 ** DLOG2;
  localparam int          FDEP  = 2;

  logic        CLK;
  logic        RST;
  logic        REQ_ADDR_VALID;
  logic [31:0] REQ_ADDR;
  logic        REQ_DATA_VALID;
  logic [31:0] REQ_DATA;
  logic        REQ_READY;
  logic        RESP_VALID;
  logic [31:0] RESP_DATA;
  logic        RESP_READY;
  logic        ERR;

  int testCount = 0;
  int failCount = 0;
  int cycleNum  = 0;

  logic [31:0] modelMem [WORDS];
  logic [31:0] expQ [$];
  bit          modelErr = 1'b0;

  mem_responder #(
    .BASE_ADDR (BASE),
    .DEPTH_LOG2(DLOG2),
    .FIFO_DEPTH(FDEP)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .REQ_ADDR_VALID(REQ_ADDR_VALID),
    .REQ_ADDR      (REQ_ADDR),
    .REQ_DATA_VALID(REQ_DATA_VALID),
    .REQ_DATA      (REQ_DATA),
    .REQ_READY     (REQ_READY),
    .RESP_VALID    (RESP_VALID),
    .RESP_DATA     (RESP_DATA),
    .RESP_READY    (RESP_READY),
    .ERR           (ERR)
  );

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
               tag, cycleNum, observed, expected);
    end
  endtask

  function automatic bit addrOk(input logic [31:0] a);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return (off >= 0) && (off < 4 * WORDS) && (a[1:0] == 2'b00);
  endfunction

  function automatic int addrIndex(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] wordAddr(input int i);
    return BASE + 32'(4 * i);
  endfunction

  // One clock cycle: drive inputs, check outputs against the model mid-cycle,
  // then advance the model exactly as the rules say the next edge will.
  task automatic applyStimulus(input bit rst, input bit av, input logic [31:0] addr,
                               input bit dv, input logic [31:0] data, input bit rr);
    bit expValid;
    bit expPop;
    bit expReady;
    bit ok;
    RST            = rst;
    REQ_ADDR_VALID = av;
    REQ_ADDR       = addr;
    REQ_DATA_VALID = dv;
    REQ_DATA       = data;
    RESP_READY     = rr;
    @(negedge CLK);
    expValid = (expQ.size() != 0);
    expPop   = expValid && rr;
    expReady = !rst && ((expQ.size() < FDEP) || expPop);
    checkOutput("REQ_READY", {31'b0, REQ_READY}, {31'b0, expReady});
    checkOutput("RESP_VALID", {31'b0, RESP_VALID}, {31'b0, expValid});
    checkOutput("ERR", {31'b0, ERR}, {31'b0, modelErr});
    if (expValid) begin
      checkOutput("RESP_DATA", RESP_DATA, expQ[0]);
    end
    if (rst) begin
      expQ.delete();
      modelErr = 1'b0;
    end else begin
      if (expPop) begin
        void'(expQ.pop_front());
      end
      if (av && expReady) begin
        ok = addrOk(addr);
        if (!ok) modelErr = 1'b1;
        if (dv) begin
          if (ok) modelMem[addrIndex(addr)] = data;
        end else begin
          expQ.push_back(ok ? modelMem[addrIndex(addr)] : 32'h0000_0000);
        end
      end
    end
    @(posedge CLK);
    #1;
    cycleNum++;
  endtask

  task automatic idle(input bit rr);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rr);
  endtask

  task automatic readWord(input int i, input bit rr);
    applyStimulus(1'b0, 1'b1, wordAddr(i), 1'b0, $urandom, rr);
  endtask

  task automatic writeWord(input int i, input logic [31:0] d, input bit rr);
    applyStimulus(1'b0, 1'b1, wordAddr(i), 1'b1, d, rr);
  endtask

  // Bound on total run time in case something stalls the bench.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    int sel;
    RST = 1'b1; REQ_ADDR_VALID = 1'b0; REQ_ADDR = '0;
    REQ_DATA_VALID = 1'b0; REQ_DATA = '0; RESP_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state and first-cycle readiness, then fill the array.
    idle(1'b0);
    for (int i = 0; i < WORDS; i++) writeWord(i, $urandom, 1'b1);

    // Write then read the same word on the next cycle.
    writeWord(2, 32'hCAFE_0001, 1'b1);
    readWord(2, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: third read stalls, then enters during the first pop.
    readWord(0, 1'b0);
    readWord(1, 1'b0);
    readWord(2, 1'b0);
    readWord(2, 1'b0);
    readWord(2, 1'b1);
    repeat (3) idle(1'b1);

    // Out-of-range read, below-base read, misaligned write; ERR stays set.
    applyStimulus(1'b0, 1'b1, BASE + 32'(4 * WORDS), 1'b0, 32'h0, 1'b1);
    idle(1'b1);
    applyStimulus(1'b0, 1'b1, BASE - 32'd4, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, BASE + 32'd2, 1'b1, 32'hDEAD_BEEF, 1'b1);
    readWord(0, 1'b1);
    readWord(1, 1'b1);
    repeat (2) idle(1'b1);

    // Streaming reads with the response side always ready; pointers wrap.
    for (int i = 0; i < 8; i++) readWord(i, 1'b1);
    repeat (2) idle(1'b1);

    // Reset with two responses pending; array contents survive.
    readWord(3, 1'b0);
    readWord(4, 1'b0);
    applyStimulus(1'b1, 1'b1, wordAddr(5), 1'b0, 32'h0, 1'b0);
    readWord(3, 1'b1);
    readWord(2, 1'b1);
    repeat (2) idle(1'b1);

    // Push and pop together while full.
    readWord(6, 1'b0);
    readWord(7, 1'b0);
    for (int i = 8; i < 14; i++) readWord(i, 1'b1);
    repeat (3) idle(1'b1);

    // Random traffic mixing every address class and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0:       a = BASE - 32'(4 * $urandom_range(1, 4));
        1:       a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 3));
        2:       a = wordAddr($urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
        default: a = wordAddr($urandom_range(0, WORDS - 1));
      endcase
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), a,
                    ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 2) != 0));
    end
    repeat (4) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
